// File: rtl/dom_pkg.sv
// Shared definitions for the DOM share generator and its LFSR.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dom_pkg;

    // Galois feedback mask for the 32-bit randomness LFSR.
    localparam logic [31:0] TAP_MASK_32 = 32'h80200003;

    // Random bits consumed per accepted transaction.
    localparam int N_RAND_BITS = 7;

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } gen_state_t;

    // Position of each field within the per-transaction random bit vector.
    localparam int R_A0  = 0;
    localparam int R_A1  = 1;
    localparam int R_B0  = 2;
    localparam int R_B1  = 3;
    localparam int R_Z10 = 4;
    localparam int R_Z20 = 5;
    localparam int R_Z21 = 6;

endpackage

// File: rtl/lfsr_galois_multistep.sv
// Galois LFSR advanced STEPS times in one cycle; rbits[k] is state[0] before step k.
// Latency: 0 (purely combinational).
// Backpressure: none; the caller decides when to commit next_state.
// Ports: state (current LFSR state), next_state (after STEPS steps),
//        rbits (one output bit per step, LSB first).
module lfsr_galois_multistep #(
    parameter int             W        = 32,
    parameter logic [W-1:0]   TAP_MASK = 32'h80200003,
    parameter int             STEPS    = 7
) (
    input  logic [W-1:0]     state,
    output logic [W-1:0]     next_state,
    output logic [STEPS-1:0] rbits
);

    logic [W-1:0] walk;

    always_comb begin
        walk  = state;
        rbits = '0;
        for (int k = 0; k < STEPS; k++) begin
            rbits[k] = walk[0];
            walk     = (walk >> 1) ^ (walk[0] ? TAP_MASK : '0);
        end
        next_state = walk;
    end

endmodule

// File: rtl/dom_share_gen_3.sv
// Splits a,b into 3 Boolean shares each and emits fresh masks z10/z20/z21 for a 3-share DOM AND.
// Latency: 1 cycle from accept to registered bundle; 1 bundle/cycle throughput.
// Backpressure: bundle held while out_valid && !out_ready; in_ready low until consumed or replaced.
// Ports: seed_load/seed/seed_err (LFSR seeding), in_valid/in_ready/a/b (operand input),
//        out_valid/out_ready/a0..a2/b0..b2/z10/z20/z21 (share bundle), reseed_req (advisory).
module dom_share_gen_3
    import dom_pkg::*;
#(
    parameter int               LFSR_W          = 32,
    parameter logic [LFSR_W-1:0] TAP_MASK       = TAP_MASK_32,
    parameter int               RESEED_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              seed_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a,
    input  logic              b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              a0,
    output logic              a1,
    output logic              a2,
    output logic              b0,
    output logic              b1,
    output logic              b2,
    output logic              z10,
    output logic              z20,
    output logic              z21,
    output logic              reseed_req
);

    localparam logic [15:0] RI = 16'(RESEED_INTERVAL);

    gen_state_t              state;
    logic [LFSR_W-1:0]       lfsr_q;
    logic [LFSR_W-1:0]       lfsr_nxt;
    logic [N_RAND_BITS-1:0]  r;
    logic [15:0]             count;
    logic                    accept;

    lfsr_galois_multistep #(
        .W        (LFSR_W),
        .TAP_MASK (TAP_MASK),
        .STEPS    (N_RAND_BITS)
    ) u_lfsr (
        .state      (lfsr_q),
        .next_state (lfsr_nxt),
        .rbits      (r)
    );

    // seed_load blocks acceptance so a reseed never races with a transaction.
    assign in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UNSEEDED;
            lfsr_q     <= '0;
            count      <= '0;
            seed_err   <= 1'b0;
            reseed_req <= 1'b0;
            out_valid  <= 1'b0;
            a0 <= 1'b0; a1 <= 1'b0; a2 <= 1'b0;
            b0 <= 1'b0; b1 <= 1'b0; b2 <= 1'b0;
            z10 <= 1'b0; z20 <= 1'b0; z21 <= 1'b0;
        end else if (seed_load) begin
            // Seeding flushes any pending bundle; an all-zero seed would lock the LFSR.
            out_valid <= 1'b0;
            if (seed != '0) begin
                lfsr_q     <= seed;
                count      <= '0;
                reseed_req <= 1'b0;
                seed_err   <= 1'b0;
                state      <= RUN;
            end else begin
                lfsr_q   <= '0;
                seed_err <= 1'b1;
                state    <= UNSEEDED;
            end
        end else if (accept) begin
            lfsr_q    <= lfsr_nxt;
            out_valid <= 1'b1;
            a0  <= r[R_A0];
            a1  <= r[R_A1];
            a2  <= a ^ r[R_A0] ^ r[R_A1];
            b0  <= r[R_B0];
            b1  <= r[R_B1];
            b2  <= b ^ r[R_B0] ^ r[R_B1];
            z10 <= r[R_Z10];
            z20 <= r[R_Z20];
            z21 <= r[R_Z21];
            if (count != RI) begin
                count <= count + 16'd1;
            end
            // Saturating count: this fires on the accept that brings count to RI.
            if (count >= RI - 16'd1) begin
                reseed_req <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dom_share_gen_3.sv
module tb_dom_share_gen_3;

    localparam int RI = 4;
    localparam logic [31:0] TAP = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [31:0] seed;
    logic        seed_err;
    logic        in_valid;
    logic        in_ready;
    logic        a, b;
    logic        out_valid;
    logic        out_ready;
    logic        a0, a1, a2, b0, b1, b2, z10, z20, z21;
    logic        reseed_req;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic        m_run;
    logic [31:0] m_lfsr;
    int          m_cnt;
    logic        m_reseed;
    logic        m_err;
    logic        m_ovld;
    logic [8:0]  m_bund;

    int accepts;
    int delivered;

    always #5 clk = ~clk;

    dom_share_gen_3 #(.RESEED_INTERVAL(RI)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .seed_err(seed_err),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .z10(z10), .z20(z20), .z21(z21), .reseed_req(reseed_req)
    );

    wire [8:0] bund = {a0, a1, a2, b0, b1, b2, z10, z20, z21};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_lfsr = '0; m_cnt = 0; m_reseed = 1'b0;
        m_err = 1'b0; m_ovld = 1'b0; m_bund = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_ovld);
        chk("bundle", bund, m_bund);
        chk("seed_err", seed_err, m_err);
        chk("reseed_req", reseed_req, m_reseed);
        chk("lfsr", dut.lfsr_q, m_lfsr);
        if (out_valid) begin
            chk("xor_a", a0 ^ a1 ^ a2, m_bund[8] ^ m_bund[7] ^ m_bund[6]);
            chk("xor_b", b0 ^ b1 ^ b2, m_bund[5] ^ m_bund[4] ^ m_bund[3]);
        end
    endtask

    // One clock: inputs already driven at posedge+1; check in_ready, clock, update model, check outputs.
    task automatic cycle();
        logic        exp_rdy, acc;
        logic [6:0]  rb;
        logic [31:0] s;
        #1;
        exp_rdy = m_run && !seed_load && (!m_ovld || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        acc = in_valid && exp_rdy;
        if (out_valid && out_ready) delivered++;
        @(posedge clk);
        if (seed_load) begin
            m_ovld = 1'b0;
            if (seed != 0) begin
                m_lfsr = seed; m_cnt = 0; m_reseed = 1'b0; m_err = 1'b0; m_run = 1'b1;
            end else begin
                m_lfsr = '0; m_err = 1'b1; m_run = 1'b0;
            end
        end else if (acc) begin
            s = m_lfsr;
            for (int k = 0; k < 7; k++) begin
                rb[k] = s[0];
                s = s[0] ? ((s >> 1) ^ TAP) : (s >> 1);
            end
            m_lfsr = s;
            m_bund = {rb[0], rb[1], a ^ rb[0] ^ rb[1],
                      rb[2], rb[3], b ^ rb[2] ^ rb[3],
                      rb[4], rb[5], rb[6]};
            m_ovld = 1'b1;
            if (m_cnt < RI) m_cnt++;
            if (m_cnt == RI) m_reseed = 1'b1;
            accepts++;
        end else if (out_ready) begin
            m_ovld = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; seed_load = 0; seed = 0; in_valid = 0; a = 0; b = 0; out_ready = 0;
        accepts = 0; delivered = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Unseeded: offered data must not be accepted
        in_valid = 1; out_ready = 1;
        repeat (2) cycle();

        // Known-answer vector from seed 1
        seed_load = 1; seed = 32'h1; in_valid = 1;
        cycle();
        seed_load = 0; a = 1; b = 0;
        cycle();
        chk("kat_bundle", bund, 9'b111_011_101);
        chk("kat_lfsr", dut.lfsr_q, 32'hB62D8003);
        chk("kat_valid", out_valid, 1'b1);

        // Zero seed is rejected, then a good seed recovers
        in_valid = 0;
        seed_load = 1; seed = 32'h0;
        cycle();
        seed_load = 0;
        cycle();
        chk("zero_seed_err", seed_err, 1'b1);
        seed_load = 1; seed = 32'h1;
        cycle();
        seed_load = 0;
        cycle();
        chk("good_seed_err", seed_err, 1'b0);
        chk("good_seed_rdy", in_ready, 1'b1);

        // Backpressure: one accept then 5 stalled cycles, then back-to-back
        in_valid = 1; a = 0; b = 1; out_ready = 0;
        cycle();
        repeat (5) cycle();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            a = i[0]; b = ~i[0];
            cycle();
            chk("b2b_valid", out_valid, 1'b1);
        end

        // Reseed interval: fresh seed, then 4 accepts
        in_valid = 0;
        seed_load = 1; seed = 32'hDEADBEEF;
        cycle();
        seed_load = 0; in_valid = 1;
        for (int i = 0; i < RI; i++) begin
            a = $urandom; b = $urandom;
            cycle();
            chk("reseed_req_step", reseed_req, (i == RI - 1) ? 1'b1 : 1'b0);
        end
        cycle(); // saturated, still advisory
        // seed_load with a pending bundle flushes it and clears reseed_req
        out_ready = 0; in_valid = 0;
        seed_load = 1; seed = 32'h12345678;
        cycle();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_reseed", reseed_req, 1'b0);
        seed_load = 0;
        cycle();

        // Random traffic
        accepts = 0; delivered = 0;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = $urandom; b = $urandom;
            cycle();
        end
        chk("bundle_count", delivered + int'(out_valid), accepts);

        // Asynchronous reset mid-stream
        in_valid = 1; out_ready = 0;
        cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("arst_in_ready", in_ready, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
